// File: rtl/dmem_access_ctrl_if.sv
// CPU request/response channel plus DataMem bus of the data-memory access controller.
// master = the controller itself, slave = the CPU datapath and DataMem around it.
interface dmem_access_ctrl_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespErr;
  logic [31:0] Address;
  logic [31:0] writeData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;

  modport master (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, ReadData,
    output ReqReady, RespValid, RespData, RespErr, Address, writeData, MemRead, MemWrite
  );

  modport slave (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, ReadData,
    input  ReqReady, RespValid, RespData, RespErr, Address, writeData, MemRead, MemWrite
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Byte/half/word load-store initiator for word-addressed DataMem (RMW for sub-word stores); MISALIGN_TRAP_EN traps misaligned accesses.
// Latency accept->RespValid: load WAIT_CYC+2, word store 2, sub-word store WAIT_CYC+3, trapped access 1.
// One request in flight; ReqReady only in IDLE; no response backpressure.
module dmem_access_ctrl #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic Clk,
  input  logic Rst_n,
  dmem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        is_store;
  logic        is_sgn;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [1:0]  req_lane;
  logic [31:0] address_q;
  logic [31:0] wdata_out;
  logic [31:0] resp_data;
  logic        mem_rd;
  logic        mem_wr;
  logic        resp_vld;

  // Lane offset used for the access; misaligned halves/words fall back to the aligned lane.
  always_comb begin
    req_lane = 2'b00;
    case (bus.ReqSize)
      2'b00:   req_lane = bus.ReqAddr[1:0];
      2'b01:   req_lane = {bus.ReqAddr[1], 1'b0};
      default: req_lane = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  logic resp_err;
  assign misalign = ((bus.ReqSize == 2'b01) && bus.ReqAddr[0]) ||
                    (bus.ReqSize[1] && (bus.ReqAddr[1:0] != 2'b00));
  assign bus.RespErr = resp_err;
`else
  assign bus.RespErr = 1'b0;
`endif

  function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] ln, input logic sx);
    logic [31:0] s;
    s = w >> {ln, 3'b000};
    case (sz)
      2'b00:   load_lane = {{24{sx & s[7]}}, s[7:0]};
      2'b01:   load_lane = {{16{sx & s[15]}}, s[15:0]};
      default: load_lane = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic half,
                                              input logic [1:0] ln, input logic [15:0] d);
    logic [31:0] mask;
    logic [31:0] ins;
    logic [4:0]  sh;
    sh = {ln, 3'b000};
    if (half) begin
      mask = 32'h0000_FFFF << sh;
      ins  = {16'h0000, d} << sh;
    end else begin
      mask = 32'h0000_00FF << sh;
      ins  = {24'h000000, d[7:0]} << sh;
    end
    store_merge = (w & ~mask) | ins;
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      is_store  <= 1'b0;
      is_sgn    <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      wdata_q   <= 16'h0000;
      address_q <= 32'h0;
      wdata_out <= 32'h0;
      resp_data <= 32'h0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      resp_vld  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      resp_err  <= 1'b0;
`endif
    end else begin
      resp_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            is_store  <= bus.ReqWrite;
            is_sgn    <= bus.ReqSigned;
            size_q    <= bus.ReqSize;
            lane_q    <= req_lane;
            wdata_q   <= bus.ReqWData[15:0];
            address_q <= {bus.ReqAddr[31:2], 2'b00};
            resp_data <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            if (misalign) begin
              state    <= RESP;
              resp_vld <= 1'b1;
              resp_err <= 1'b1;
            end else
`endif
            if (bus.ReqWrite && bus.ReqSize[1]) begin
              state     <= WR;
              mem_wr    <= 1'b1;
              wdata_out <= bus.ReqWData;
            end else begin
              state    <= RD;
              mem_rd   <= 1'b1;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        RD: begin
          // Last read cycle: ReadData is consumed straight into the response or the merged word.
          if (wait_cnt == 4'd0) begin
            mem_rd <= 1'b0;
            if (is_store) begin
              state     <= WR;
              mem_wr    <= 1'b1;
              wdata_out <= store_merge(bus.ReadData, size_q[0], lane_q, wdata_q);
            end else begin
              state     <= RESP;
              resp_vld  <= 1'b1;
              resp_data <= load_lane(bus.ReadData, size_q, lane_q, is_sgn);
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WR: begin
          mem_wr    <= 1'b0;
          state     <= RESP;
          resp_vld  <= 1'b1;
          resp_data <= 32'h0;
        end
        RESP: begin
          state <= IDLE;
`ifdef MISALIGN_TRAP_EN
          resp_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ReqReady  = (state == IDLE) && Rst_n;
  assign bus.Address   = address_q;
  assign bus.writeData = wdata_out;
  assign bus.MemRead   = mem_rd;
  assign bus.MemWrite  = mem_wr;
  assign bus.RespValid = resp_vld;
  assign bus.RespData  = resp_data;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboarded bench for dmem_access_ctrl with a behavioural DataMem; build with or without MISALIGN_TRAP_EN.
module tb_dmem_access_ctrl;
  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  dmem_access_ctrl_if bus ();
  dmem_access_ctrl #(.WAIT_CYC(1)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  logic [31:0] mem [0:63];
  assign bus.ReadData = mem[bus.Address[7:2]];
  always @(posedge Clk) if (Rst_n && bus.MemWrite) mem[bus.Address[7:2]] <= bus.writeData;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } resp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  resp_t mr;
  wr_t   mw;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdc = 0;
  int wrc = 0;
  int a1, a2, ax;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic resp_t mk(input logic [31:0] d, input logic e, input int l, input int nr, input int nw);
    resp_t r;
    r.data = d; r.err = e; r.lat = l; r.nrd = nr; r.nwr = nw; r.acc = 0;
    return r;
  endfunction

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  // Drives one request, pushes its expectation just before the accepting edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic want, input resp_t r, output int acc);
    int n;
    n = 0;
    bus.ReqWrite = wr; bus.ReqSize = sz; bus.ReqSigned = sg; bus.ReqAddr = a; bus.ReqWData = wd;
    bus.ReqValid = 1'b1;
    while (!bus.ReqReady && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no ReqReady in %0d cycles, expected accept", n);
      bus.ReqValid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    r.acc = acc;
    if (want) rq.push_back(r);
    @(posedge Clk);
    @(negedge Clk);
    bus.ReqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", rq.size());
      rq.delete(); wq.delete();
    end
    @(negedge Clk);
  endtask

  always @(negedge Clk) begin
    if (!Rst_n) begin
      rdc = 0;
      wrc = 0;
    end else begin
      chk("rd_wr_exclusive", {31'b0, bus.MemRead & bus.MemWrite}, 32'd0);
      if (bus.MemRead) rdc++;
      if (bus.MemWrite) begin
        wrc++;
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got write 0x%08h @0x%08h, expected none", bus.writeData, bus.Address);
        end else begin
          mw = wq.pop_front();
          chk("wr_addr", bus.Address, mw.addr);
          chk("wr_data", bus.writeData, mw.data);
        end
      end
      if (bus.RespValid) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got RespValid data 0x%08h, expected none", bus.RespData);
        end else begin
          mr = rq.pop_front();
          chk("resp_data", bus.RespData, mr.data);
          chk("resp_err", {31'b0, bus.RespErr}, {31'b0, mr.err});
          chk("resp_latency", 32'(cyc - mr.acc + 1), 32'(mr.lat));
          chk("memread_cycles", 32'(rdc), 32'(mr.nrd));
          chk("memwrite_cycles", 32'(wrc), 32'(mr.nwr));
        end
        rdc = 0;
        wrc = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    Rst_n = 1'b0;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqSize = 2'b10; bus.ReqSigned = 1'b0;
    bus.ReqAddr = 32'h10; bus.ReqWData = 32'h1234_5678;

    repeat (3) begin
      @(negedge Clk);
      chk("rst_ctrl", {27'b0, bus.ReqReady, bus.MemRead, bus.MemWrite, bus.RespValid, bus.RespErr}, 32'd0);
      chk("rst_address", bus.Address, 32'h0);
      chk("rst_writedata", bus.writeData, 32'h0);
      chk("rst_respdata", bus.RespData, 32'h0);
    end
    bus.ReqValid = 1'b0;
    Rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'b0, bus.ReqReady}, 32'd1);
    chk("no_write_in_rst", mem[4], 32'h0);
    @(negedge Clk);

    // Word store then word load
    push_wr(32'h10, 32'hDEAD_BEEF);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, mk(32'h0, 1'b0, 2, 0, 1), ax);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, mk(32'hDEAD_BEEF, 1'b0, 3, 2, 0), ax);

    // Lane extraction from 0x80F01234
    push_wr(32'h20, 32'h80F0_1234);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80F0_1234, 1'b1, mk(32'h0, 1'b0, 2, 0, 1), ax);
    issue(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b1, mk(32'hFFFF_FF80, 1'b0, 3, 2, 0), ax);
    issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b1, mk(32'h0000_0080, 1'b0, 3, 2, 0), ax);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b1, mk(32'hFFFF_80F0, 1'b0, 3, 2, 0), ax);
    issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b1, mk(32'h0000_1234, 1'b0, 3, 2, 0), ax);
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b1, mk(32'h0000_0012, 1'b0, 3, 2, 0), ax);
    drain();

    // Sub-word read-modify-write
    push_wr(32'h20, 32'h1122_3344);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b1, mk(32'h0, 1'b0, 2, 0, 1), ax);
    push_wr(32'h20, 32'h1122_AB44);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB, 1'b1, mk(32'h0, 1'b0, 4, 2, 1), ax);
    push_wr(32'h20, 32'hCAFE_AB44);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_CAFE, 1'b1, mk(32'h0, 1'b0, 4, 2, 1), ax);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, mk(32'hCAFE_AB44, 1'b0, 3, 2, 0), a1);
    issue(1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 1'b1, mk(32'hCAFE_AB44, 1'b0, 3, 2, 0), a2);
    chk("b2b_accept_spacing", 32'(a2 - a1), 32'd4);
    drain();
    chk("mem_after_rmw", mem[8], 32'hCAFE_AB44);

    // Misaligned accesses
    push_wr(32'h04, 32'h5566_7788);
    issue(1'b1, 2'b10, 1'b0, 32'h04, 32'h5566_7788, 1'b1, mk(32'h0, 1'b0, 2, 0, 1), ax);
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, mk(32'h0, 1'b1, 1, 0, 0), ax);
    issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b1, mk(32'h0, 1'b1, 1, 0, 0), ax);
    issue(1'b1, 2'b01, 1'b0, 32'h23, 32'h0000_BEEF, 1'b1, mk(32'h0, 1'b1, 1, 0, 0), ax);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, mk(32'h5566_7788, 1'b0, 3, 2, 0), ax);
    issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b1, mk(32'h0000_AB44, 1'b0, 3, 2, 0), ax);
`endif
    drain();
    chk("mem_after_misalign", mem[8], 32'hCAFE_AB44);

    // Reset during the read phase of a sub-word store
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0000, 1'b0, mk(32'h0, 1'b0, 0, 0, 0), ax);
    chk("abort_in_rd", {31'b0, bus.MemRead}, 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("abort_async_drop", {29'b0, bus.MemRead, bus.MemWrite, bus.RespValid}, 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (6) @(negedge Clk);
    chk("abort_word_unchanged", mem[8], 32'hCAFE_AB44);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, mk(32'hCAFE_AB44, 1'b0, 3, 2, 0), ax);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
